// File: rtl/awb_gain.sv
// awb_gain: gray-world auto white balance.
//   Captures the R/G/B frame means, computes gain_r = G/R and gain_b = G/B with a
//   sequential restoring divider (one quotient bit per cycle), and applies the
//   committed gains to the pixel stream. G and untagged pixels pass at unity gain.
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   mean_valid_i, r/g/b_mean_i      1-cycle mean strobe and the three frame means
//   valid_i, color_i, value_i, last_i   input pixel stream (0=R 1=G 2=B 3=other)
//   valid_o, color_o, value_o, last_o   balanced pixel stream, latency 2
//   gain_r_o, gain_b_o              gains currently applied (unsigned, FRAC_BITS fraction)
//   busy_o                          high while the divider sequence runs
module awb_gain #(
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 6,
    parameter int GAIN_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mean_valid_i,
    input  logic [DATA_W-1:0] r_mean_i,
    input  logic [DATA_W-1:0] g_mean_i,
    input  logic [DATA_W-1:0] b_mean_i,
    input  logic              valid_i,
    input  logic [1:0]        color_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [1:0]        color_o,
    output logic [DATA_W-1:0] value_o,
    output logic              last_o,
    output logic [GAIN_W-1:0] gain_r_o,
    output logic [GAIN_W-1:0] gain_b_o,
    output logic              busy_o
);

    localparam int DIV_CYC = DATA_W + FRAC_BITS;
    localparam int CNT_W   = $clog2(DIV_CYC);
    localparam int PROD_W  = DATA_W + GAIN_W;
    localparam logic [GAIN_W-1:0] GAIN_ONE  = {{(GAIN_W-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [GAIN_W-1:0] GAIN_MAX  = {GAIN_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV_CYC - 1);
    localparam logic [PROD_W:0]   ROUND_ADD = {{PROD_W{1'b0}}, 1'b1} << (FRAC_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV_R = 2'd1,
        DIV_B = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a full-width quotient to the representable gain range.
    function automatic logic [GAIN_W-1:0] sat_gain(input logic [DIV_CYC-1:0] q);
        logic [GAIN_W-1:0] res;
        if (|q[DIV_CYC-1:GAIN_W]) begin
            res = GAIN_MAX;
        end else begin
            res = q[GAIN_W-1:0];
        end
        return res;
    endfunction

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [DATA_W-1:0]   r_mean_r, g_mean_r, b_mean_r;
    logic [DATA_W-1:0]   rem_r;
    logic [DIV_CYC-1:0]  quo_r;
    logic [GAIN_W-1:0]   quot_r_r, quot_b_r;
    logic [GAIN_W-1:0]   shadow_r_r, shadow_b_r, active_r_r, active_b_r;
    logic                pending_r, frame_open_r, busy_r;

    logic                load_s, dividing_s, cnt_last_s, done_s, commit_s;
    logic [DATA_W-1:0]   divisor_s, rem_next_s;
    logic [DATA_W:0]     trial_s;
    logic                ge_s;
    logic [DIV_CYC-1:0]  quo_next_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; means arriving outside IDLE are simply dropped.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    if (mean_valid_i) state_next_s = DIV_R; else state_next_s = IDLE;
            DIV_R:   if (cnt_last_s)   state_next_s = DIV_B; else state_next_s = DIV_R;
            DIV_B:   if (cnt_last_s)   state_next_s = DONE;  else state_next_s = DIV_B;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: divider control strobes.
    always_comb begin
        load_s     = 1'b0;
        dividing_s = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            IDLE:    load_s     = mean_valid_i;
            DIV_R:   dividing_s = 1'b1;
            DIV_B:   dividing_s = 1'b1;
            DONE:    done_s     = 1'b1;
            default: load_s     = 1'b0;
        endcase
    end

    assign cnt_last_s = (cnt_r == CNT_LAST);
    assign commit_s   = pending_r & ~frame_open_r & ~valid_i & ~done_s;

    // One restoring-division step. A zero divisor makes every trial succeed,
    // so the quotient goes to all ones and saturates.
    always_comb begin
        if (state_r == DIV_B) begin
            divisor_s = b_mean_r;
        end else begin
            divisor_s = r_mean_r;
        end
        trial_s = {rem_r, quo_r[DIV_CYC-1]};
        ge_s    = (trial_s >= {1'b0, divisor_s});
        if (ge_s) begin
            rem_next_s = DATA_W'(trial_s - {1'b0, divisor_s});
        end else begin
            rem_next_s = trial_s[DATA_W-1:0];
        end
        quo_next_s = {quo_r[DIV_CYC-2:0], ge_s};
    end

    // Divider datapath: mean capture, shift/subtract, quotient capture per colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mean_r <= '0;
            g_mean_r <= '0;
            b_mean_r <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
            cnt_r    <= '0;
            quot_r_r <= GAIN_ONE;
            quot_b_r <= GAIN_ONE;
            busy_r   <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            if (load_s) begin
                r_mean_r <= r_mean_i;
                g_mean_r <= g_mean_i;
                b_mean_r <= b_mean_i;
                rem_r    <= '0;
                quo_r    <= {g_mean_i, {FRAC_BITS{1'b0}}};
                cnt_r    <= '0;
            end else if (dividing_s) begin
                if (cnt_last_s) begin
                    // Reload the same dividend for the blue pass.
                    rem_r <= '0;
                    quo_r <= {g_mean_r, {FRAC_BITS{1'b0}}};
                    cnt_r <= '0;
                    if (state_r == DIV_R) begin
                        quot_r_r <= sat_gain(quo_next_s);
                    end else begin
                        quot_b_r <= sat_gain(quo_next_s);
                    end
                end else begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Shadow/active gains: DONE loads the shadow (overwriting any uncommitted one);
    // the shadow moves to active only between frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r_r   <= GAIN_ONE;
            shadow_b_r   <= GAIN_ONE;
            active_r_r   <= GAIN_ONE;
            active_b_r   <= GAIN_ONE;
            pending_r    <= 1'b0;
            frame_open_r <= 1'b0;
        end else begin
            if (valid_i) begin
                frame_open_r <= ~last_i;
            end else begin
                frame_open_r <= frame_open_r;
            end
            if (done_s) begin
                shadow_r_r <= quot_r_r;
                shadow_b_r <= quot_b_r;
                pending_r  <= 1'b1;
            end else if (commit_s) begin
                active_r_r <= shadow_r_r;
                active_b_r <= shadow_b_r;
                pending_r  <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Pixel pipeline signals.
    logic [GAIN_W-1:0]           pix_gain_s;
    logic [PROD_W-1:0]           prod_s, prod_r;
    logic [PROD_W:0]             round_sum_s;
    logic [PROD_W-FRAC_BITS:0]   shifted_s;
    logic [DATA_W-1:0]           pix_sat_s;
    logic                        s1_valid_r, s1_last_r;
    logic [1:0]                  s1_color_r;
    logic                        valid_r, last_r;
    logic [1:0]                  color_r;
    logic [DATA_W-1:0]           value_r;

    // Per-colour gain select and S1 multiply operand.
    always_comb begin
        case (color_i)
            2'd0:    pix_gain_s = active_r_r;
            2'd2:    pix_gain_s = active_b_r;
            default: pix_gain_s = GAIN_ONE;
        endcase
        prod_s = PROD_W'(value_i) * PROD_W'(pix_gain_s);
    end

    // S2 round-half-up and clamp to the pixel range.
    always_comb begin
        round_sum_s = {1'b0, prod_r} + ROUND_ADD;
        shifted_s   = round_sum_s[PROD_W:FRAC_BITS];
        if (|shifted_s[PROD_W-FRAC_BITS:DATA_W]) begin
            pix_sat_s = {DATA_W{1'b1}};
        end else begin
            pix_sat_s = shifted_s[DATA_W-1:0];
        end
    end

    // Two-stage pixel pipe; value_o holds its last value while no pixel is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_color_r <= 2'd0;
            prod_r     <= '0;
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
            color_r    <= 2'd0;
            value_r    <= '0;
        end else begin
            s1_valid_r <= valid_i;
            s1_last_r  <= valid_i & last_i;
            s1_color_r <= color_i;
            prod_r     <= prod_s;
            valid_r    <= s1_valid_r;
            last_r     <= s1_last_r;
            color_r    <= s1_color_r;
            if (s1_valid_r) begin
                value_r <= pix_sat_s;
            end else begin
                value_r <= value_r;
            end
        end
    end

    assign valid_o  = valid_r;
    assign last_o   = last_r;
    assign color_o  = color_r;
    assign value_o  = value_r;
    assign gain_r_o = active_r_r;
    assign gain_b_o = active_b_r;
    assign busy_o   = busy_r;

endmodule
